// File: rtl/dffsr_pkg.sv
// Shared types and limits for the set/reset flip-flop bank.
package dffsr_pkg;

    typedef enum logic {
        PRIO_RESET = 1'b0,
        PRIO_SET   = 1'b1
    } dffsr_prio_t;

    localparam int unsigned MAX_Q_DELAY = 4;

endpackage

// File: rtl/dffsr_bank_if.sv
// Request/data/status bundle for dffsr_bank; the master drives requests, the bank returns state.
interface dffsr_bank_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] nset;
    logic [WIDTH-1:0] nreset;
    logic             ce;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] changed;

    modport master (
        output nset, nreset, ce, d,
        input  q, changed
    );

    modport slave (
        input  nset, nreset, ce, d,
        output q, changed
    );

endinterface

// File: rtl/dffsr_slice.sv
// One set/reset bit: force requests, one-edge release hold, enabled capture with unknown-data fallback.
module dffsr_slice
    import dffsr_pkg::*;
#(
    parameter logic        INIT_BIT = 1'b0,
    parameter dffsr_prio_t PRIO     = PRIO_RESET
) (
    input  logic clk,
    input  logic reset,
    input  logic nset,
    input  logic nreset,
    input  logic ce,
    input  logic d,
    output logic ff,
    output logic ff_nxt
);

    logic nset_q;
    logic nreset_q;
    logic prio_val;

    assign prio_val = (PRIO == PRIO_SET);

    // Next state is exposed so the bank can register its change strobe in step with ff.
    always_comb begin
        ff_nxt = ff;
        if (!nreset && !nset)
            ff_nxt = prio_val;
        else if (!nreset)
            ff_nxt = 1'b0;
        else if (!nset)
            ff_nxt = 1'b1;
        else if (!nreset_q && !nset_q)
            ff_nxt = prio_val;
        else if (!nreset_q)
            ff_nxt = 1'b0;
        else if (!nset_q)
            ff_nxt = 1'b1;
        else if (ce)
            ff_nxt = $isunknown(d) ? INIT_BIT : d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ff       <= INIT_BIT;
            nset_q   <= 1'b1;
            nreset_q <= 1'b1;
        end else begin
            ff       <= ff_nxt;
            nset_q   <= nset;
            nreset_q <= nreset;
        end
    end

endmodule

// File: rtl/dffsr_bank.sv
// WIDTH-bit bank of synchronous set/reset flops with optional output delay pipeline and change strobe.
module dffsr_bank
    import dffsr_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter dffsr_prio_t      PRIO    = PRIO_RESET,
    parameter int unsigned      Q_DELAY = 0
) (
    input  logic         clk,
    input  logic         reset,
    dffsr_bank_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("dffsr_bank: WIDTH must be in 1..64");
    end
    if (Q_DELAY > MAX_Q_DELAY) begin : g_bad_delay
        $error("dffsr_bank: Q_DELAY exceeds MAX_Q_DELAY");
    end

    logic [WIDTH-1:0] ff;
    logic [WIDTH-1:0] ff_nxt;
    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] changed_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dffsr_slice #(
            .INIT_BIT (INIT[i]),
            .PRIO     (PRIO)
        ) u_slice (
            .clk    (clk),
            .reset  (reset),
            .nset   (bus.nset[i]),
            .nreset (bus.nreset[i]),
            .ce     (bus.ce),
            .d      (bus.d[i]),
            .ff     (ff[i]),
            .ff_nxt (ff_nxt[i])
        );
    end

    // q_nxt is whatever q will hold after the coming edge, so changed lines up with q.
    if (Q_DELAY == 0) begin : g_direct
        assign q_int = ff;
        assign q_nxt = ff_nxt;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [Q_DELAY];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned s = 0; s < Q_DELAY; s++)
                    pipe[s] <= INIT;
            end else begin
                pipe[0] <= ff;
                for (int unsigned s = 1; s < Q_DELAY; s++)
                    pipe[s] <= pipe[s-1];
            end
        end

        assign q_int = pipe[Q_DELAY-1];
        if (Q_DELAY == 1) begin : g_nxt_ff
            assign q_nxt = ff;
        end else begin : g_nxt_pipe
            assign q_nxt = pipe[Q_DELAY-2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            changed_r <= '0;
        else
            changed_r <= q_nxt ^ q_int;
    end

    assign bus.q       = q_int;
    assign bus.changed = changed_r;

endmodule
